afe_sequencer: RTL
==================

AFE_SEQUENCER -- requirements
Module: afe_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, giving the number of cycles from LED/config switch to first ADC sample.
REQ-002 SHALL have parameter AVG_LOG2, default 2, where 2^AVG_LOG2 is the number of ADC samples averaged per channel phase.
REQ-003 SHALL have parameter DARK_CYCLES, default 2, giving the cycles with both LEDs off between channel phases.
REQ-004 SHALL have the following ports (name, direction, width, meaning):
  CLK  in  1  single system clock; all logic on posedge.
  rst  in  1  synchronous active-high reset.
  start  in  1  one-cycle pulse that begins sequencing (settings already found).
  stop  in  1  one-cycle pulse that requests a return to IDLE.
  RED_DC_Comp  in  7  DC compensation code for RED.
  RED_PGA  in  4  PGA gain for RED.
  IR_DC_Comp  in  7  DC compensation code for IR.
  IR_PGA  in  4  PGA gain for IR.
  ADC  in  8  front-end ADC sample.
  out_ready  in  1  downstream accepts a result.
  LED_RED  out  1  RED LED drive.
  LED_IR  out  1  IR LED drive.
  DC_Comp  out  7  DC compensation applied to the AFE.
  PGA_Gain  out  4  PGA gain applied to the AFE.
  out_valid  out  1  result available.
  out_is_ir  out  1  result channel (0 = RED, 1 = IR).
  out_data  out  8  averaged sample.
  overrun  out  1  sticky flag: a result was dropped.
  busy  out  1  high whenever state is not IDLE.

Function
REQ-005 SHALL implement states IDLE, RED_SETTLE, RED_SAMPLE, DARK_A, IR_SETTLE, IR_SAMPLE, DARK_B.
REQ-006 SHALL move IDLE->RED_SETTLE on start; start SHALL be ignored outside IDLE.
REQ-007 SHALL follow the transitions RED_SETTLE->RED_SAMPLE->DARK_A->IR_SETTLE->IR_SAMPLE->DARK_B->RED_SETTLE, staying in each state exactly SETTLE_CYCLES, 2^AVG_LOG2 and DARK_CYCLES cycles respectively.
REQ-008 SHALL capture the relevant channel's DC_Comp/PGA_Gain inputs onto the outputs on the cycle a SETTLE state is entered; the outputs SHALL hold that value until the next SETTLE entry, so a mid-phase input change has no effect.
REQ-009 SHALL drive LED_RED=1 only in RED_SETTLE and RED_SAMPLE, and LED_IR=1 only in IR_SETTLE and IR_SAMPLE; LED_RED and LED_IR SHALL never both be 1.
REQ-010 SHALL clear the accumulator (8+AVG_LOG2 bits, unsigned) on SAMPLE entry and add ADC once per SAMPLE cycle; the accumulator SHALL not overflow.
REQ-011 SHALL form the result as accumulator >> AVG_LOG2 (truncating) and present it with out_valid=1 on the cycle after the last SAMPLE cycle, together with out_is_ir for that channel.
REQ-012 SHALL hold out_valid, out_data and out_is_ir until the cycle after out_valid && out_ready, which is the transfer.
REQ-013 SHALL, if a new result completes while out_valid=1 and out_ready=0, drop the new result, keep the old one and set overrun; if out_ready=1 in that same cycle, the new result SHALL replace the old and overrun SHALL stay unchanged.
REQ-014 SHALL record a stop pulse as pending; a pending stop SHALL take effect at the end of the current DARK_A or DARK_B, moving to IDLE instead of continuing; a stop in IDLE SHALL be ignored.
REQ-015 SHALL, on simultaneous start and stop in IDLE, start.
REQ-016 SHALL leave a pending output result valid on entering IDLE, still transferable.
REQ-017 SHALL clear overrun only by rst.

Reset
REQ-018 SHALL, on rst=1 at posedge CLK, set state=IDLE, LED_RED=0, LED_IR=0, DC_Comp=0, PGA_Gain=0, out_valid=0, out_is_ir=0, out_data=0, overrun=0, busy=0, accumulator=0, counters=0 and stop-pending=0.
REQ-019 SHALL let rst mid-phase abort immediately, discarding any partial average; rst SHALL take priority over start and stop.

Structure
REQ-020 SHALL place the state enumeration and the default parameter values in shared package afe_seq_pkg.
REQ-021 SHALL implement the clear/accumulate/shift datapath as sub-module afe_accum, instantiated once.
REQ-022 SHALL register all outputs.

Verification
REQ-023 SHALL cover: defaults, ADC constant 100, start, out_ready=1 -> results alternate RED/IR with out_data=100 each, period 2*(4+4+2)=20 cycles.
REQ-024 SHALL cover: RED phase ADC sequence 10,20,30,41 -> out_data=25 (101>>2), out_is_ir=0, valid 1 cycle after the 4th sample.
REQ-025 SHALL cover: RED_DC_Comp=50, RED_PGA=3, IR_DC_Comp=90, IR_PGA=9; change RED_DC_Comp to 60 mid RED_SAMPLE -> DC_Comp stays 50 until the next RED_SETTLE, then becomes 60; LEDs never both 1.
REQ-026 SHALL cover: out_ready=0 across two results -> first result held, overrun=1 from the second completion; out_ready=1 -> first result transfers, overrun stays 1.
REQ-027 SHALL cover: stop during IR_SAMPLE -> IR result still produced; IDLE after DARK_B, busy=0, LEDs 0.
REQ-028 SHALL cover: rst in RED_SAMPLE after 2 samples -> all outputs at reset values next cycle; restart gives a correct full 4-sample average.

Source files
------------

// File: rtl/afe_seq_pkg.sv
// Shared state encoding and default timing parameters for the AFE LED/ADC sequencer.
package afe_seq_pkg;

    localparam int unsigned SETTLE_CYCLES_DEF = 4;
    localparam int unsigned AVG_LOG2_DEF      = 2;
    localparam int unsigned DARK_CYCLES_DEF   = 2;

    typedef enum logic [2:0] {
        StIdle,
        StRedSettle,
        StRedSample,
        StDarkA,
        StIrSettle,
        StIrSample,
        StDarkB
    } afe_state_e;

endpackage

// File: rtl/afe_accum.sv
// Sample accumulator: clears on the first sample of a phase, adds one ADC sample per cycle,
// and exposes the truncated average including the sample being added this cycle.
module afe_accum
    import afe_seq_pkg::*;
#(
    parameter int unsigned AVG_LOG2 = AVG_LOG2_DEF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       first_i,
    input  logic       en_i,
    input  logic [7:0] adc_i,
    output logic [7:0] avg_o
);

    localparam int unsigned AccW = 8 + AVG_LOG2;

    logic [AccW-1:0] acc_q, acc_d;
    logic [AccW-1:0] sum;

    always_comb begin
        sum   = (first_i ? '0 : acc_q) + AccW'(adc_i);
        acc_d = en_i ? sum : acc_q;
        avg_o = 8'(sum >> AVG_LOG2);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/afe_sequencer.sv
// Alternates RED and IR LED phases, settles the AFE, averages ADC samples per phase and
// offers each average on a valid/ready output with a sticky overrun flag.
module afe_sequencer
    import afe_seq_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int unsigned AVG_LOG2      = AVG_LOG2_DEF,
    parameter int unsigned DARK_CYCLES   = DARK_CYCLES_DEF
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic [6:0] RED_DC_Comp,
    input  logic [3:0] RED_PGA,
    input  logic [6:0] IR_DC_Comp,
    input  logic [3:0] IR_PGA,
    input  logic [7:0] ADC,
    input  logic       out_ready,
    output logic       LED_RED,
    output logic       LED_IR,
    output logic [6:0] DC_Comp,
    output logic [3:0] PGA_Gain,
    output logic       out_valid,
    output logic       out_is_ir,
    output logic [7:0] out_data,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned Samples = 1 << AVG_LOG2;

    afe_state_e  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] phase_len;
    logic        stop_pend_q, stop_pend_d;
    logic        last_cyc;
    logic        sampling, first_sample, result_done;
    logic [7:0]  avg;

    logic       led_red_q, led_red_d;
    logic       led_ir_q, led_ir_d;
    logic [6:0] dc_q, dc_d;
    logic [3:0] pga_q, pga_d;
    logic       valid_q, valid_d;
    logic       is_ir_q, is_ir_d;
    logic [7:0] data_q, data_d;
    logic       overrun_q, overrun_d;
    logic       busy_q, busy_d;

    always_comb begin
        unique case (state_q)
            StRedSettle, StIrSettle: phase_len = 16'(SETTLE_CYCLES);
            StRedSample, StIrSample: phase_len = 16'(Samples);
            StDarkA, StDarkB:        phase_len = 16'(DARK_CYCLES);
            default:                 phase_len = 16'd1;
        endcase
        last_cyc     = (state_q != StIdle) && (cnt_q == phase_len - 16'd1);
        sampling     = (state_q == StRedSample) || (state_q == StIrSample);
        first_sample = sampling && (cnt_q == 16'd0);
        result_done  = sampling && last_cyc;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = last_cyc ? 16'd0 : cnt_q + 16'd1;
        stop_pend_d = stop_pend_q;

        unique case (state_q)
            StIdle: begin
                cnt_d = 16'd0;
                if (start) state_d = StRedSettle;
            end
            StRedSettle: if (last_cyc) state_d = StRedSample;
            StRedSample: if (last_cyc) state_d = StDarkA;
            StDarkA:     if (last_cyc) state_d = (stop_pend_q || stop) ? StIdle : StIrSettle;
            StIrSettle:  if (last_cyc) state_d = StIrSample;
            StIrSample:  if (last_cyc) state_d = StDarkB;
            StDarkB:     if (last_cyc) state_d = (stop_pend_q || stop) ? StIdle : StRedSettle;
            default:     state_d = StIdle;
        endcase

        if (state_q != StIdle && stop) stop_pend_d = 1'b1;
        if (state_d == StIdle) stop_pend_d = 1'b0;
    end

    // Output registers are loaded from next-state so they line up with state_q.
    always_comb begin
        led_red_d = (state_d == StRedSettle) || (state_d == StRedSample);
        led_ir_d  = (state_d == StIrSettle) || (state_d == StIrSample);
        busy_d    = (state_d != StIdle);

        dc_d  = dc_q;
        pga_d = pga_q;
        if (state_d == StRedSettle && state_q != StRedSettle) begin
            dc_d  = RED_DC_Comp;
            pga_d = RED_PGA;
        end else if (state_d == StIrSettle && state_q != StIrSettle) begin
            dc_d  = IR_DC_Comp;
            pga_d = IR_PGA;
        end

        valid_d   = valid_q;
        is_ir_d   = is_ir_q;
        data_d    = data_q;
        overrun_d = overrun_q;
        if (result_done) begin
            if (!valid_q || out_ready) begin
                valid_d = 1'b1;
                data_d  = avg;
                is_ir_d = (state_q == StIrSample);
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 16'd0;
            stop_pend_q <= 1'b0;
            led_red_q   <= 1'b0;
            led_ir_q    <= 1'b0;
            dc_q        <= 7'd0;
            pga_q       <= 4'd0;
            valid_q     <= 1'b0;
            is_ir_q     <= 1'b0;
            data_q      <= 8'd0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stop_pend_q <= stop_pend_d;
            led_red_q   <= led_red_d;
            led_ir_q    <= led_ir_d;
            dc_q        <= dc_d;
            pga_q       <= pga_d;
            valid_q     <= valid_d;
            is_ir_q     <= is_ir_d;
            data_q      <= data_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    afe_accum #(
        .AVG_LOG2(AVG_LOG2)
    ) u_accum (
        .clk_i  (CLK),
        .rst_i  (rst),
        .first_i(first_sample),
        .en_i   (sampling),
        .adc_i  (ADC),
        .avg_o  (avg)
    );

    assign LED_RED   = led_red_q;
    assign LED_IR    = led_ir_q;
    assign DC_Comp   = dc_q;
    assign PGA_Gain  = pga_q;
    assign out_valid = valid_q;
    assign out_is_ir = is_ir_q;
    assign out_data  = data_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;

endmodule
